hex_display_mux: RTL

- Parametrised multiplexed hex display driver for N-digit common-anode 7-segment banks. Successor to the fixed 4-digit driver.
- Adds the following:
  - configurable digit count and refresh divider;
  - per-digit decimal points and blanking;
  - global enable;
  - frame-coherent data snapshot (no tearing mid-scan);
  - frame-start strobe.
- Sits between core/debug registers and board anode/cathode pins.

---
 rtl/hex_display_mux_if.sv | 23 ++
 rtl/hex_display_mux.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hex_display_mux_if.sv
// Pin-side bundle of the multiplexed hex display driver: digit data, per-digit
// controls and the scanned anode/cathode/frame outputs.
interface hex_display_mux_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] data;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   blank;
  logic                  enable;
  logic [N_DIGITS-1:0]   anode;
  logic [7:0]            catode;
  logic                  frame_tick;

  modport master (
    output data, dp_in, blank, enable,
    input  anode, catode, frame_tick
  );

  modport slave (
    input  data, dp_in, blank, enable,
    output anode, catode, frame_tick
  );
endinterface

// File: rtl/hex_display_mux.sv
// N-digit multiplexed common-anode 7-segment driver with frame-coherent snapshot.
// Optional leading-zero blanking is built when HEXDISP_LZB_EN is defined.
module hex_display_mux #(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 100000
) (
  input  logic             clk,
  input  logic             reset,
  hex_display_mux_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

`ifdef HEXDISP_LZB_EN
  // Blank zero digits from the top down until one is non-zero or has its dp lit.
  function automatic logic [N_DIGITS-1:0] lzb_mask(input logic [4*N_DIGITS-1:0] d,
                                                    input logic [N_DIGITS-1:0]   p);
    logic [N_DIGITS-1:0] m;
    logic                lead;
    m    = '0;
    lead = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (lead && (d[4*i +: 4] == 4'h0) && !p[i])
        m[i] = 1'b1;
      else
        lead = 1'b0;
    end
    return m;
  endfunction
`endif

  logic [CW-1:0]         count_p0;
  logic [IW-1:0]         idx_p0;
  logic [IW-1:0]         next_p0;
  logic                  tick_p0;
  logic                  frame_start_p0;
  logic [4*N_DIGITS-1:0] snap_data_p0;
  logic [N_DIGITS-1:0]   snap_dp_p0;
  logic [N_DIGITS-1:0]   snap_blank_p0;
  logic [N_DIGITS-1:0]   src_dp;
  logic [N_DIGITS-1:0]   src_blank;
  logic [4*N_DIGITS-1:0] src_data;
  logic [31:0]           src_data_w;
  logic [7:0]            src_dp_w;
  logic [7:0]            src_blank_w;
  logic [2:0]            sel;
  logic [3:0]            nib_sel;
  logic                  dp_sel;
  logic                  show_sel;
  logic [N_DIGITS-1:0]   anode_p1;
  logic [7:0]            catode_p1;
  logic                  frame_tick_p1;

`ifdef HEXDISP_LZB_EN
  logic [N_DIGITS-1:0]   lzb_live;
  logic [N_DIGITS-1:0]   snap_lzb_p0;
  assign lzb_live = lzb_mask(bus.data, bus.dp_in);
`endif

  assign tick_p0        = (count_p0 == CNT_MAX);
  assign next_p0        = (idx_p0 == IDX_MAX) ? '0 : idx_p0 + IW'(1);
  assign frame_start_p0 = tick_p0 && (next_p0 == '0);

  // Digit 0 of a frame reads the live inputs, which are the ones being captured.
  always_comb begin
    src_data  = (next_p0 == '0) ? bus.data  : snap_data_p0;
    src_dp    = (next_p0 == '0) ? bus.dp_in : snap_dp_p0;
`ifdef HEXDISP_LZB_EN
    src_blank = (next_p0 == '0) ? (bus.blank | lzb_live) : (snap_blank_p0 | snap_lzb_p0);
`else
    src_blank = (next_p0 == '0) ? bus.blank : snap_blank_p0;
`endif
    src_data_w  = 32'(src_data);
    src_dp_w    = 8'(src_dp);
    src_blank_w = 8'(src_blank);
    sel         = 3'(next_p0);
    nib_sel     = src_data_w[{sel, 2'b00} +: 4];
    dp_sel      = src_dp_w[sel];
    show_sel    = bus.enable && !src_blank_w[sel];
  end

  // Stage p0 -> p1: divider, scan index, snapshot and registered pin outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_p0      <= '0;
      idx_p0        <= IDX_MAX;
      snap_data_p0  <= '0;
      snap_dp_p0    <= '0;
      snap_blank_p0 <= '0;
`ifdef HEXDISP_LZB_EN
      snap_lzb_p0   <= '0;
`endif
      anode_p1      <= '1;
      catode_p1     <= 8'hFF;
      frame_tick_p1 <= 1'b0;
    end else begin
      frame_tick_p1 <= frame_start_p0;
      count_p0      <= tick_p0 ? '0 : count_p0 + CW'(1);
      if (tick_p0) begin
        idx_p0 <= next_p0;
        if (show_sel) begin
          anode_p1  <= ~(N_DIGITS'(1) << next_p0);
          catode_p1 <= {~dp_sel, hex7(nib_sel)};
        end else begin
          anode_p1  <= '1;
          catode_p1 <= 8'hFF;
        end
      end
      if (frame_start_p0) begin
        snap_data_p0  <= bus.data;
        snap_dp_p0    <= bus.dp_in;
        snap_blank_p0 <= bus.blank;
`ifdef HEXDISP_LZB_EN
        snap_lzb_p0   <= lzb_live;
`endif
      end
    end
  end

  assign bus.anode      = anode_p1;
  assign bus.catode     = catode_p1;
  assign bus.frame_tick = frame_tick_p1;

endmodule
